// File: rtl/pipe_flush_ctrl.sv
// Front-end PC / pipeline-register control: branch misprediction recovery, load-use stalls,
// HLT handling, and a saturating misprediction counter. The FSM state is exported on `state`.
module pipe_flush_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             jump_pred,
    input  logic [15:0]      jump_pred_adr,
    input  logic             jump_pred_miss,
    input  logic             jump_pred_adr_miss,
    input  logic [15:0]      pcinc_evac,
    input  logic [15:0]      ALUres_mem,
    input  logic             load_use,
    input  logic             halt_id,
    input  logic             restart,
    input  logic [15:0]      pcinc_if,
    output logic [15:0]      pc_next,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] mispred_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        STALL   = 2'd1,
        RECOVER = 2'd2,
        HALT    = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   recovery;

    assign recovery = jump_pred_miss | jump_pred_adr_miss;
    assign state    = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_next      = pcinc_if;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;

        if (reset) begin
            pc_next      = 16'h0000;
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            state_d      = RUN;
        end else if (recovery) begin
            // A resolved taken branch wins over the fall-through when both misses fire.
            pc_next      = jump_pred_adr_miss ? ALUres_mem : pcinc_evac;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            state_d      = RECOVER;
        end else begin
            case (state_q)
                HALT: begin
                    pc_we       = 1'b0;
                    if_id_we    = 1'b0;
                    flush_id_ex = 1'b1;
                    state_d     = restart ? RUN : HALT;
                end
                RECOVER: begin
                    // ID holds a wrong-path instruction's successor: predictions and
                    // load-use are stale here, only a real HLT is acted on.
                    if (halt_id) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        flush_id_ex = 1'b1;
                        state_d     = HALT;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    if (halt_id) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        flush_id_ex = 1'b1;
                        state_d     = HALT;
                    end else if (load_use) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        flush_id_ex = 1'b1;
                        state_d     = STALL;
                    end else if (jump_pred) begin
                        pc_next = jump_pred_adr;
                        state_d = RUN;
                    end else begin
                        state_d = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mispred_cnt <= '0;
        end else if (recovery && (mispred_cnt != {CNT_W{1'b1}})) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Directed bench for pipe_flush_ctrl: one task per scenario with inline checks.
// A second instance with CNT_W=4 shares all inputs to observe counter saturation.
module tb_pipe_flush_ctrl;

    logic        clk;
    logic        reset;
    logic        jump_pred;
    logic [15:0] jump_pred_adr;
    logic        jump_pred_miss;
    logic        jump_pred_adr_miss;
    logic [15:0] pcinc_evac;
    logic [15:0] ALUres_mem;
    logic        load_use;
    logic        halt_id;
    logic        restart;
    logic [15:0] pcinc_if;

    logic [15:0] pc_next;
    logic        pc_we, if_id_we;
    logic        flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]  state;
    logic [15:0] mispred_cnt;

    logic [15:0] pc_next_4;
    logic        pc_we_4, if_id_we_4;
    logic        flush_if_id_4, flush_id_ex_4, flush_ex_mem_4;
    logic [1:0]  state_4;
    logic [3:0]  mispred_cnt_4;

    int checks;
    int errors;

    pipe_flush_ctrl dut (
        .clk(clk), .reset(reset), .jump_pred(jump_pred), .jump_pred_adr(jump_pred_adr),
        .jump_pred_miss(jump_pred_miss), .jump_pred_adr_miss(jump_pred_adr_miss),
        .pcinc_evac(pcinc_evac), .ALUres_mem(ALUres_mem), .load_use(load_use),
        .halt_id(halt_id), .restart(restart), .pcinc_if(pcinc_if),
        .pc_next(pc_next), .pc_we(pc_we), .if_id_we(if_id_we),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .state(state), .mispred_cnt(mispred_cnt)
    );

    pipe_flush_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .jump_pred(jump_pred), .jump_pred_adr(jump_pred_adr),
        .jump_pred_miss(jump_pred_miss), .jump_pred_adr_miss(jump_pred_adr_miss),
        .pcinc_evac(pcinc_evac), .ALUres_mem(ALUres_mem), .load_use(load_use),
        .halt_id(halt_id), .restart(restart), .pcinc_if(pcinc_if),
        .pc_next(pc_next_4), .pc_we(pc_we_4), .if_id_we(if_id_we_4),
        .flush_if_id(flush_if_id_4), .flush_id_ex(flush_id_ex_4), .flush_ex_mem(flush_ex_mem_4),
        .state(state_4), .mispred_cnt(mispred_cnt_4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic idle_inputs();
        jump_pred = 0; jump_pred_adr = 16'h0; jump_pred_miss = 0; jump_pred_adr_miss = 0;
        pcinc_evac = 16'h0; ALUres_mem = 16'h0; load_use = 0; halt_id = 0; restart = 0;
        pcinc_if = 16'h0005;
    endtask

    task automatic wait_edge();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk); idle_inputs(); reset = 1; jump_pred_miss = 1; #1;
        checks++; if (pc_we !== 0 || if_id_we !== 0) begin errors++;
            $display("FAIL reset_we got %b%b exp 00", pc_we, if_id_we); end
        checks++; if ({flush_if_id, flush_id_ex, flush_ex_mem} !== 3'b111) begin errors++;
            $display("FAIL reset_flush got %b exp 111", {flush_if_id, flush_id_ex, flush_ex_mem}); end
        checks++; if (pc_next !== 16'h0000) begin errors++;
            $display("FAIL reset_pc_next got %h exp 0000", pc_next); end
        wait_edge();
        checks++; if (state !== 2'd0 || mispred_cnt !== 16'h0) begin errors++;
            $display("FAIL reset_state got %0d/%h exp 0/0000", state, mispred_cnt); end
        @(negedge clk); reset = 0; idle_inputs();
    endtask

    task automatic test_normal();
        @(negedge clk); idle_inputs(); pcinc_if = 16'h0021; restart = 1; #1;
        checks++; if (pc_next !== 16'h0021 || pc_we !== 1 || if_id_we !== 1) begin errors++;
            $display("FAIL normal_pc got %h/%b/%b exp 0021/1/1", pc_next, pc_we, if_id_we); end
        checks++; if ({flush_if_id, flush_id_ex, flush_ex_mem} !== 3'b000) begin errors++;
            $display("FAIL normal_flush got %b exp 000", {flush_if_id, flush_id_ex, flush_ex_mem}); end
        wait_edge();
        checks++; if (state !== 2'd0) begin errors++;
            $display("FAIL normal_restart_ignored got %0d exp 0", state); end
    endtask

    task automatic test_jump_pred();
        @(negedge clk); idle_inputs(); jump_pred = 1; jump_pred_adr = 16'h0040; #1;
        checks++; if (pc_next !== 16'h0040 || pc_we !== 1) begin errors++;
            $display("FAIL jp_pc got %h/%b exp 0040/1", pc_next, pc_we); end
        wait_edge();
        checks++; if (state !== 2'd0) begin errors++;
            $display("FAIL jp_state got %0d exp 0", state); end
    endtask

    task automatic test_mispred();
        @(negedge clk); idle_inputs(); jump_pred_miss = 1; pcinc_evac = 16'h0013;
        jump_pred = 1; jump_pred_adr = 16'h0777; #1;
        checks++; if (pc_next !== 16'h0013 || pc_we !== 1) begin errors++;
            $display("FAIL miss_pc got %h/%b exp 0013/1", pc_next, pc_we); end
        checks++; if ({flush_if_id, flush_id_ex, flush_ex_mem} !== 3'b111) begin errors++;
            $display("FAIL miss_flush got %b exp 111", {flush_if_id, flush_id_ex, flush_ex_mem}); end
        wait_edge();
        checks++; if (state !== 2'd2 || mispred_cnt !== 16'd1) begin errors++;
            $display("FAIL miss_state got %0d/%0d exp 2/1", state, mispred_cnt); end
        // in RECOVER, prediction and load-use are ignored
        @(negedge clk); idle_inputs(); jump_pred = 1; jump_pred_adr = 16'h0777;
        load_use = 1; pcinc_if = 16'h0014; #1;
        checks++; if (pc_next !== 16'h0014 || pc_we !== 1 || flush_id_ex !== 0) begin errors++;
            $display("FAIL recover_ignore got %h/%b/%b exp 0014/1/0", pc_next, pc_we, flush_id_ex); end
        wait_edge();
        checks++; if (state !== 2'd0 || mispred_cnt !== 16'd1) begin errors++;
            $display("FAIL recover_exit got %0d/%0d exp 0/1", state, mispred_cnt); end
    endtask

    task automatic test_both_miss();
        @(negedge clk); idle_inputs(); jump_pred_miss = 1; jump_pred_adr_miss = 1;
        pcinc_evac = 16'h0013; ALUres_mem = 16'h0200; #1;
        checks++; if (pc_next !== 16'h0200) begin errors++;
            $display("FAIL both_pc got %h exp 0200", pc_next); end
        wait_edge();
        checks++; if (state !== 2'd2 || mispred_cnt !== 16'd2) begin errors++;
            $display("FAIL both_cnt got %0d/%0d exp 2/2", state, mispred_cnt); end
        @(negedge clk); idle_inputs(); wait_edge();
    endtask

    task automatic test_load_use();
        @(negedge clk); idle_inputs(); load_use = 1; jump_pred = 1; jump_pred_adr = 16'h0040; #1;
        checks++; if (pc_we !== 0 || if_id_we !== 0 || flush_id_ex !== 1) begin errors++;
            $display("FAIL lu_outs got %b/%b/%b exp 0/0/1", pc_we, if_id_we, flush_id_ex); end
        wait_edge();
        checks++; if (state !== 2'd1) begin errors++;
            $display("FAIL lu_state got %0d exp 1", state); end
        @(negedge clk); idle_inputs(); load_use = 1; wait_edge();
        checks++; if (state !== 2'd1) begin errors++;
            $display("FAIL lu_restall got %0d exp 1", state); end
        @(negedge clk); idle_inputs(); jump_pred = 1; jump_pred_adr = 16'h0055; #1;
        checks++; if (pc_next !== 16'h0055 || pc_we !== 1 || if_id_we !== 1 || flush_id_ex !== 0) begin errors++;
            $display("FAIL stall_outs got %h/%b/%b/%b exp 0055/1/1/0", pc_next, pc_we, if_id_we, flush_id_ex); end
        wait_edge();
        checks++; if (state !== 2'd0) begin errors++;
            $display("FAIL stall_exit got %0d exp 0", state); end
    endtask

    task automatic test_halt();
        @(negedge clk); idle_inputs(); halt_id = 1; load_use = 1; #1;
        checks++; if (pc_we !== 0 || if_id_we !== 0 || flush_id_ex !== 1) begin errors++;
            $display("FAIL halt_outs got %b/%b/%b exp 0/0/1", pc_we, if_id_we, flush_id_ex); end
        wait_edge();
        checks++; if (state !== 2'd3) begin errors++;
            $display("FAIL halt_state got %0d exp 3", state); end
        @(negedge clk); idle_inputs(); #1;
        checks++; if (pc_we !== 0 || flush_id_ex !== 1) begin errors++;
            $display("FAIL halt_hold got %b/%b exp 0/1", pc_we, flush_id_ex); end
        wait_edge();
        checks++; if (state !== 2'd3) begin errors++;
            $display("FAIL halt_stay got %0d exp 3", state); end
        @(negedge clk); idle_inputs(); restart = 1; wait_edge();
        checks++; if (state !== 2'd0) begin errors++;
            $display("FAIL halt_restart got %0d exp 0", state); end
    endtask

    task automatic test_halt_recover();
        @(negedge clk); idle_inputs(); halt_id = 1; wait_edge();
        @(negedge clk); idle_inputs(); jump_pred_adr_miss = 1; ALUres_mem = 16'h0100; #1;
        checks++; if (pc_next !== 16'h0100 || pc_we !== 1) begin errors++;
            $display("FAIL hrec_pc got %h/%b exp 0100/1", pc_next, pc_we); end
        wait_edge();
        checks++; if (state !== 2'd2 || mispred_cnt !== 16'd3) begin errors++;
            $display("FAIL hrec_state got %0d/%0d exp 2/3", state, mispred_cnt); end
        @(negedge clk); idle_inputs(); wait_edge();
        checks++; if (state !== 2'd0) begin errors++;
            $display("FAIL hrec_exit got %0d exp 0", state); end
    endtask

    task automatic test_recover_halt();
        @(negedge clk); idle_inputs(); jump_pred_miss = 1; wait_edge();
        @(negedge clk); idle_inputs(); halt_id = 1; #1;
        checks++; if (pc_we !== 0 || if_id_we !== 0) begin errors++;
            $display("FAIL rech_outs got %b/%b exp 0/0", pc_we, if_id_we); end
        wait_edge();
        checks++; if (state !== 2'd3 || mispred_cnt !== 16'd4) begin errors++;
            $display("FAIL rech_state got %0d/%0d exp 3/4", state, mispred_cnt); end
        @(negedge clk); idle_inputs(); restart = 1; wait_edge();
    endtask

    task automatic test_saturation();
        @(negedge clk); idle_inputs(); reset = 1; wait_edge();
        @(negedge clk); reset = 0; jump_pred_miss = 1;
        for (int i = 0; i < 16; i++) wait_edge();
        checks++; if (mispred_cnt_4 !== 4'hF || mispred_cnt !== 16'd16) begin errors++;
            $display("FAIL sat_16 got %h/%0d exp f/16", mispred_cnt_4, mispred_cnt); end
        wait_edge();
        checks++; if (mispred_cnt_4 !== 4'hF || mispred_cnt !== 16'd17) begin errors++;
            $display("FAIL sat_hold got %h/%0d exp f/17", mispred_cnt_4, mispred_cnt); end
        @(negedge clk); idle_inputs(); wait_edge();
        checks++; if (state !== 2'd0 || mispred_cnt_4 !== 4'hF) begin errors++;
            $display("FAIL sat_exit got %0d/%h exp 0/f", state, mispred_cnt_4); end
    endtask

    task automatic test_reset_in_halt();
        @(negedge clk); idle_inputs(); halt_id = 1; wait_edge();
        checks++; if (state !== 2'd3) begin errors++;
            $display("FAIL rh_enter got %0d exp 3", state); end
        @(negedge clk); idle_inputs(); reset = 1; jump_pred_adr_miss = 1; ALUres_mem = 16'h0300; #1;
        checks++; if (pc_next !== 16'h0000 || pc_we !== 0) begin errors++;
            $display("FAIL rh_outs got %h/%b exp 0000/0", pc_next, pc_we); end
        wait_edge();
        checks++; if (state !== 2'd0 || mispred_cnt !== 16'd0 || mispred_cnt_4 !== 4'h0) begin errors++;
            $display("FAIL rh_state got %0d/%0d/%0d exp 0/0/0", state, mispred_cnt, mispred_cnt_4); end
        @(negedge clk); reset = 0; idle_inputs(); wait_edge();
        checks++; if (state !== 2'd0) begin errors++;
            $display("FAIL rh_after got %0d exp 0", state); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        test_reset();
        test_normal();
        test_jump_pred();
        test_mispred();
        test_both_miss();
        test_load_use();
        test_halt();
        test_halt_recover();
        test_recover_halt();
        test_saturation();
        test_reset_in_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_flush_ctrl.md
PIPE_FLUSH_CTRL -- requirements
Module: pipe_flush_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of misprediction counter.
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: jump_pred  in  1  predictor hit for branch in ID this cycle.
REQ-004 SHALL have: jump_pred_adr  in  16  predicted target.
REQ-005 SHALL have: jump_pred_miss  in  1  predicted-taken branch in MEM not taken.
REQ-006 SHALL have: jump_pred_adr_miss  in  1  branch in MEM taken, target not predicted or mispredicted.
REQ-007 SHALL have: pcinc_evac  in  16  fall-through PC of the mispredicted branch.
REQ-008 SHALL have: ALUres_mem  in  16  resolved branch target in MEM.
REQ-009 SHALL have: load_use  in  1  load-use hazard detected in ID.
REQ-010 SHALL have: halt_id  in  1  HLT instruction in ID.
REQ-011 SHALL have: restart  in  1  single-cycle resume pulse.
REQ-012 SHALL have outputs: pc_next  out  16  next PC value; pc_we  out  1  PC write enable; if_id_we  out  1  IF/ID register enable.
REQ-013 SHALL have outputs: flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  bubble insertion into named register.
REQ-014 SHALL have outputs: state  out  2  FSM state; mispred_cnt  out  CNT_W  misprediction count.
REQ-015 SHALL have input pcinc_if  in  16  PC+1 from IF.

Function
REQ-016 SHALL implement FSM: RUN=0, STALL=1, RECOVER=2, HALT=3.
REQ-017 SHALL resolve events with priority: recovery (miss or adr_miss) > halt_id > load_use > jump_pred.
REQ-018 Recovery SHALL act combinationally in the detecting cycle, from any state: flush_if_id=flush_id_ex=flush_ex_mem=1, pc_we=1, next state RECOVER.
REQ-019 Recovery SHALL set pc_next=pcinc_evac on jump_pred_miss, ALUres_mem on jump_pred_adr_miss; both high SHALL select ALUres_mem.
REQ-020 RECOVER SHALL last exactly one cycle; jump_pred SHALL be ignored (pc_next=pcinc_if), load_use ignored, halt_id honoured; then RUN or HALT.
REQ-021 halt_id in RUN or STALL without recovery SHALL give pc_we=0, if_id_we=0, flush_id_ex=1, next HALT.
REQ-022 HALT SHALL hold pc_we=0, if_id_we=0, flush_id_ex=1 until restart, then next RUN; restart outside HALT SHALL be ignored.
REQ-023 Recovery during HALT SHALL override halt (squashed HLT) and enter RECOVER.
REQ-024 load_use in RUN SHALL give pc_we=0, if_id_we=0, flush_id_ex=1, next STALL.
REQ-025 STALL SHALL last one cycle with normal RUN outputs; load_use in STALL SHALL re-stall (remain STALL).
REQ-026 jump_pred in RUN/STALL without higher event SHALL give pc_next=jump_pred_adr, pc_we=1.
REQ-027 Otherwise pc_next=pcinc_if, pc_we=1, if_id_we=1, all flushes 0.
REQ-028 mispred_cnt SHALL increment by one per recovery cycle and saturate at all-ones (no wrap).
REQ-029 mispred_cnt SHALL increment once when both miss inputs high.
REQ-030 All outputs except state and mispred_cnt SHALL be combinational from state and inputs.

Reset
REQ-031 reset SHALL force state=RUN, mispred_cnt=0 on the next clk edge, overriding all events including mid-recovery or HALT.
REQ-032 While reset is high outputs SHALL be pc_we=0, if_id_we=0, all flushes=1, pc_next=0.

Verification
REQ-033 RUN, jump_pred=1, jump_pred_adr=0x0040 -> pc_next=0x0040, pc_we=1, state stays 0.
REQ-034 RUN, jump_pred_miss=1, pcinc_evac=0x0013 -> pc_next=0x0013, three flushes=1, state=2 next, then 0; mispred_cnt 0->1.
REQ-035 HALT, jump_pred_adr_miss=1, ALUres_mem=0x0100 -> pc_next=0x0100, state=2 then 0 (halt squashed).
REQ-036 load_use and jump_pred both in RUN -> pc_we=0, flush_id_ex=1, state=1; jump_pred ignored.
REQ-037 CNT_W=4, 16 recoveries -> mispred_cnt=0xF held, no wrap.
REQ-038 reset asserted while state=3 -> state=0, mispred_cnt=0 next cycle; restart not required.
